// File: rtl/usb_line_tx_if.sv
// Bit-level handshake between the packet encoder and the USB line transmitter.
// The encoder is the master and offers one bit per cycle. The transmitter is the
// slave and pulls bits with bit_ready.
interface usb_line_tx_if;
  logic bit_in;
  logic bit_valid;
  logic bit_last;
  logic bit_ready;

  modport master (
    output bit_in,
    output bit_valid,
    output bit_last,
    input  bit_ready
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  bit_last,
    output bit_ready
  );
endinterface

// File: rtl/usb_line_tx.sv
// USB line transmitter.
// Each packet is framed as SYNC, the bit-stuffed data and an SE0/J end-of-packet.
// Every symbol is NRZI-coded and registered onto dp/dm/oe.
// The lvl register holds the NRZI line level: 1 means J, 0 means K.
module usb_line_tx #(
  parameter int LOW_SPEED = 0,
  parameter int MAX_ONES  = 6,
  parameter int SE0_BITS  = 2,
  parameter int J_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst_b,
  usb_line_tx_if.slave bus,
  output logic         dp,
  output logic         dm,
  output logic         oe,
  output logic         busy,
  output logic         underrun
);

  // The phase counter is shared by SYNC and both EOP phases.
  localparam int PH_MAX = (SE0_BITS > 8) ? ((J_BITS > SE0_BITS) ? J_BITS : SE0_BITS)
                                         : ((J_BITS > 8) ? J_BITS : 8);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int ONES_W = $clog2(MAX_ONES + 1);

  localparam logic [PH_W-1:0]   SYNC_LAST = PH_W'(7);
  localparam logic [PH_W-1:0]   SE0_LAST  = PH_W'(SE0_BITS - 1);
  localparam logic [PH_W-1:0]   J_LAST    = PH_W'(J_BITS - 1);
  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(MAX_ONES);
  localparam logic [ONES_W-1:0] ONES_ONE  = ONES_W'(1);
  localparam logic              LS_POL    = (LOW_SPEED != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t             state_q, state_d;
  logic               lvl_q, lvl_d;
  logic               se0_d;
  logic               oe_q, oe_d;
  logic               dp_q, dm_q;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic               pend_q, pend_d;
  logic               und_q, und_d;

  logic               stuff_now;
  logic               stuff_next;
  logic [ONES_W-1:0]  ones_inc;

  // NRZI: a 0 toggles the line level and a 1 holds it.
  function automatic logic nrzi(input logic lvl, input logic b);
    return b ? lvl : ~lvl;
  endfunction

  // Map a line level to dp. The low-speed J state has dp=0.
  function automatic logic level_dp(input logic lvl, input logic se0);
    return se0 ? 1'b0 : (lvl ^ LS_POL);
  endfunction

  // Map a line level to dm.
  function automatic logic level_dm(input logic lvl, input logic se0);
    return se0 ? 1'b0 : ~(lvl ^ LS_POL);
  endfunction

  // A stuffed 0 is owed whenever the run of ones has reached MAX_ONES.
  // The run already includes the final SYNC 1.
  assign stuff_now  = (state_q == S_DATA) && (ones_q == ONES_MAX);
  assign ones_inc   = ones_q + ONES_ONE;
  assign stuff_next = bus.bit_in && (ones_inc == ONES_MAX);

  assign bus.bit_ready = (state_q == S_DATA) && !stuff_now;
  assign busy          = (state_q != S_IDLE);
  assign dp            = dp_q;
  assign dm            = dm_q;
  assign oe            = oe_q;
  assign underrun      = und_q;

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A new packet may only start once the line has shown
  // at least one idle (oe=0) symbol.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.bit_valid && !oe_q) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (ph_q == SYNC_LAST) state_d = S_DATA;
      end
      S_DATA: begin
        if (stuff_now) begin
          if (pend_q) state_d = S_EOP_SE0;
        end else if (!bus.bit_valid) begin
          // The first SE0 is driven on the abort edge itself.
          state_d = (SE0_BITS == 1) ? S_EOP_J : S_EOP_SE0;
        end else if (bus.bit_last && !stuff_next) begin
          state_d = S_EOP_SE0;
        end
      end
      S_EOP_SE0: begin
        if (ph_q == SE0_LAST) state_d = S_EOP_J;
      end
      S_EOP_J: begin
        if (ph_q == J_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic. Computes the symbol that is registered at this
  // edge together with the counters.
  always_comb begin
    lvl_d  = lvl_q;
    se0_d  = 1'b0;
    oe_d   = 1'b1;
    ones_d = ones_q;
    ph_d   = ph_q;
    pend_d = pend_q;
    und_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        lvl_d  = 1'b1;
        oe_d   = 1'b0;
        ones_d = '0;
        ph_d   = '0;
        pend_d = 1'b0;
        if (bus.bit_valid && !oe_q) begin
          // The first SYNC symbol (a 0) goes out on the start edge.
          lvl_d = nrzi(1'b1, 1'b0);
          oe_d  = 1'b1;
          ph_d  = PH_ONE;
        end
      end
      S_SYNC: begin
        lvl_d = nrzi(lvl_q, ph_q == SYNC_LAST);
        if (ph_q == SYNC_LAST) begin
          ones_d = ONES_ONE;
          ph_d   = '0;
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      S_DATA: begin
        ph_d = '0;
        if (stuff_now) begin
          lvl_d  = nrzi(lvl_q, 1'b0);
          ones_d = '0;
          pend_d = 1'b0;
        end else if (!bus.bit_valid) begin
          se0_d  = 1'b1;
          und_d  = 1'b1;
          ones_d = '0;
          ph_d   = (SE0_BITS == 1) ? '0 : PH_ONE;
        end else begin
          lvl_d  = nrzi(lvl_q, bus.bit_in);
          ones_d = bus.bit_in ? ones_inc : '0;
          pend_d = bus.bit_last && stuff_next;
        end
      end
      S_EOP_SE0: begin
        se0_d = 1'b1;
        ph_d  = (ph_q == SE0_LAST) ? '0 : ph_q + PH_ONE;
      end
      S_EOP_J: begin
        lvl_d = 1'b1;
        if (ph_q == J_LAST) begin
          ph_d   = '0;
          ones_d = '0;
          pend_d = 1'b0;
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      default: begin
        lvl_d  = 1'b1;
        oe_d   = 1'b0;
        ones_d = '0;
        ph_d   = '0;
        pend_d = 1'b0;
      end
    endcase
  end

  // Line and counter registers. Reset parks the line at J with the pads released.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lvl_q  <= 1'b1;
      dp_q   <= level_dp(1'b1, 1'b0);
      dm_q   <= level_dm(1'b1, 1'b0);
      oe_q   <= 1'b0;
      ones_q <= '0;
      ph_q   <= '0;
      pend_q <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      dp_q   <= level_dp(lvl_d, se0_d);
      dm_q   <= level_dm(lvl_d, se0_d);
      oe_q   <= oe_d;
      ones_q <= ones_d;
      ph_q   <= ph_d;
      pend_q <= pend_d;
      und_q  <= und_d;
    end
  end

endmodule

// File: tb/tb_usb_line_tx.sv
// Bench for usb_line_tx. It drives a full-speed default instance and a low-speed
// instance (SE0_BITS=3, J_BITS=2) through one shared stimulus path. The
// reference model builds the expected line symbols from the packet bits:
// SYNC, then stuffing over the bit stream, then NRZI, then the EOP.
module tb_usb_line_tx;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic sel = 1'b0;
  logic drv_valid = 1'b0;
  logic drv_bit = 1'b0;
  logic drv_last = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  logic pkt [64];
  logic [1:0] exp_q [$];
  logic [1:0] obs_q [$];

  usb_line_tx_if if_a ();
  usb_line_tx_if if_b ();

  logic dp_a, dm_a, oe_a, busy_a, und_a;
  logic dp_b, dm_b, oe_b, busy_b, und_b;
  logic m_dp, m_dm, m_oe, m_busy, m_und, m_rdy;

  assign if_a.bit_in    = drv_bit;
  assign if_a.bit_last  = drv_last;
  assign if_a.bit_valid = drv_valid & ~sel;
  assign if_b.bit_in    = drv_bit;
  assign if_b.bit_last  = drv_last;
  assign if_b.bit_valid = drv_valid & sel;

  assign m_dp   = sel ? dp_b   : dp_a;
  assign m_dm   = sel ? dm_b   : dm_a;
  assign m_oe   = sel ? oe_b   : oe_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_und  = sel ? und_b  : und_a;
  assign m_rdy  = sel ? if_b.bit_ready : if_a.bit_ready;

  usb_line_tx u_fs (
    .clk      (clk),
    .rst_b    (rst_b),
    .bus      (if_a),
    .dp       (dp_a),
    .dm       (dm_a),
    .oe       (oe_a),
    .busy     (busy_a),
    .underrun (und_a)
  );

  usb_line_tx #(
    .LOW_SPEED (1),
    .MAX_ONES  (6),
    .SE0_BITS  (3),
    .J_BITS    (2)
  ) u_ls (
    .clk      (clk),
    .rst_b    (rst_b),
    .bus      (if_b),
    .dp       (dp_b),
    .dm       (dm_b),
    .oe       (oe_b),
    .busy     (busy_b),
    .underrun (und_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encode the J or K level as {dp,dm}. j=1 means J.
  function automatic logic [1:0] sym(input logic ls, input logic j);
    logic d;
    d = ls ? ~j : j;
    return {d, ~d};
  endfunction

  // Reference model: builds the expected symbols for the first n_send bits of pkt.
  function automatic void build_exp(input logic ls, input int se0n, input int jn, input int n_send);
    logic stream [$];
    logic line [$];
    int run;
    logic lvl;
    exp_q.delete();
    for (int i = 0; i < 8; i++) stream.push_back(i == 7);
    for (int i = 0; i < n_send; i++) stream.push_back(pkt[i]);
    run = 0;
    foreach (stream[i]) begin
      line.push_back(stream[i]);
      run = stream[i] ? run + 1 : 0;
      if (run == 6) begin
        line.push_back(1'b0);
        run = 0;
      end
    end
    lvl = 1'b1;
    foreach (line[i]) begin
      if (!line[i]) lvl = ~lvl;
      exp_q.push_back(sym(ls, lvl));
    end
    for (int i = 0; i < se0n; i++) exp_q.push_back(2'b00);
    for (int i = 0; i < jn; i++) exp_q.push_back(sym(ls, 1'b1));
  endfunction

  // Send one packet of n_bits from pkt. If n_abort >= 0, bit_valid drops
  // after n_abort bits without any bit_last. Captures every oe=1 symbol.
  task automatic run_pkt(input logic sel_i, input int n_bits, input int n_abort, input string tag);
    int idx, nsend, und_cnt, und_bad, n;
    logic pend, seen_oe, fin;
    sel = sel_i;
    obs_q.delete();
    idx = 0; pend = 1'b0; seen_oe = 1'b0; fin = 1'b0; und_cnt = 0; und_bad = 0;
    nsend = (n_abort >= 0) ? n_abort : n_bits;
    build_exp(sel_i, sel_i ? 3 : 2, sel_i ? 2 : 1, nsend);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      if (m_oe) begin
        seen_oe = 1'b1;
        obs_q.push_back({m_dp, m_dm});
      end else if (seen_oe) begin
        fin = 1'b1;
      end
      if (m_und) begin
        und_cnt++;
        if ({m_dp, m_dm} != 2'b00 || !m_oe || !m_busy) und_bad++;
      end
      if (pend) idx++;
      if (idx < nsend) begin
        drv_valid = 1'b1;
        drv_bit   = pkt[idx];
        drv_last  = (n_abort < 0) && (idx == n_bits - 1);
      end else begin
        drv_valid = 1'b0;
        drv_bit   = 1'b0;
        drv_last  = 1'b0;
      end
      pend = drv_valid && m_rdy;
    end
    check($sformatf("%s done", tag), 32'(fin), 32'd1);
    check($sformatf("%s xfers", tag), 32'(idx), 32'(nsend));
    check($sformatf("%s oe_len", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s sym%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    check($sformatf("%s und_cnt", tag), 32'(und_cnt), (n_abort >= 0) ? 32'd1 : 32'd0);
    check($sformatf("%s und_se0", tag), 32'(und_bad), 32'd0);
  endtask

  task automatic load(input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) pkt[i] = bits[i];
  endtask

  initial begin
    int len, ab;
    for (int i = 0; i < 64; i++) pkt[i] = 1'b0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst fs dpdm", {30'd0, dp_a, dm_a}, 32'b10);
    check("rst fs oe", 32'(oe_a), 32'd0);
    check("rst fs busy", 32'(busy_a), 32'd0);
    check("rst fs rdy", 32'(if_a.bit_ready), 32'd0);
    check("rst fs und", 32'(und_a), 32'd0);
    check("rst ls dpdm", {30'd0, dp_b, dm_b}, 32'b01);
    check("rst ls oe", 32'(oe_b), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Full-speed ACK: 8 SYNC + 8 data + 2 SE0 + 1 J = 19 symbols.
    load(64'b11010010, 8);
    run_pkt(1'b0, 8, -1, "ack_fs");
    check("ack_fs 19", 32'(obs_q.size()), 32'd19);

    // A stuffed bit lands in the middle of the packet.
    load(64'hFF, 8);
    run_pkt(1'b0, 8, -1, "stuff_mid");

    // A stuffed bit follows the final data bit.
    load(64'b1111110, 7);
    run_pkt(1'b0, 7, -1, "stuff_end");

    // bit_valid drops after three data bits.
    load(64'b010, 3);
    run_pkt(1'b0, 8, 3, "underrun");

    // Low-speed ACK: 8 + 8 + 3 + 2 = 21 symbols.
    load(64'b11010010, 8);
    run_pkt(1'b1, 8, -1, "ack_ls");
    check("ack_ls 21", 32'(obs_q.size()), 32'd21);

    // Reset asserted in the middle of the data phase.
    sel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drv_valid = 1'b1;
      drv_bit   = 1'($urandom_range(0, 1));
      drv_last  = 1'b0;
    end
    check("mid oe", 32'(oe_a), 32'd1);
    check("mid busy", 32'(busy_a), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("rstmid oe", 32'(oe_a), 32'd0);
    check("rstmid dpdm", {30'd0, dp_a, dm_a}, 32'b10);
    check("rstmid busy", 32'(busy_a), 32'd0);
    check("rstmid rdy", 32'(if_a.bit_ready), 32'd0);
    @(negedge clk);
    drv_valid = 1'b0;
    rst_b = 1'b1;
    load(64'b11010010, 8);
    run_pkt(1'b0, 8, -1, "after_rst");

    // Random packets on both instances, some aborted.
    for (int p = 0; p < 14; p++) begin
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) pkt[i] = ($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : -1;
      run_pkt(1'($urandom_range(0, 1)), len, ab, $sformatf("rnd%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_line_tx.md
# usb_line_tx

USB line transmitter: takes the raw packet bitstream from the encoder and drives it onto the bus. It generates SYNC, performs bit stuffing and NRZI encoding, terminates each packet with SE0/J, and drives the bus output enable. It sits between the packet encoder/CRC stage and the DP/DM pads. It succeeds the fixed-length DP/DM writer with per-packet framing from a `last` flag, bit stuffing, NRZI, speed-selectable polarity, configurable EOP, and underrun abort.

## Interface
- LOW_SPEED, 0: 0 = full speed (J: dp=1, dm=0); 1 = low speed (J: dp=0, dm=1). K is always the inverse of J.
- MAX_ONES, 6: number of consecutive 1s after which a stuffed 0 is inserted.
- SE0_BITS, 2: EOP SE0 length in bit times (≥1).
- J_BITS, 1: EOP trailing J length in bit times (≥1).
- clk  in  1  bit clock; one line symbol per cycle.
- rst_b  in  1  asynchronous, active-low reset.
- bit_in  in  1  data bit, LSB-first order as supplied by the encoder.
- bit_valid  in  1  bit_in is valid; held high for a whole packet.
- bit_last  in  1  qualifies bit_in as the final packet bit.
- bit_ready  out  1  block accepts bit_in this cycle.
- dp, dm  out  1 each  registered line outputs.
- oe  out  1  registered pad output enable.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle pulse when a packet is aborted.

## Operation
- Reset values: dp/dm = J, oe=0, bit_ready=0, busy=0, underrun=0, state IDLE, ones counter 0.
- Line register: NRZI state `lvl`, reset to J. Data 0 toggles `lvl`; data 1 holds it. The driven dp/dm equal `lvl` except during SE0.
- Transfer: a bit is transferred on a clock edge where bit_valid & bit_ready.
- **IDLE**
  - dp/dm = J, oe=0, bit_ready=0.
  - bit_valid=1 → SYNC, with the SYNC counter cleared.
- **SYNC**
  - 8 cycles emitting 0,0,0,0,0,0,0,1 through NRZI, with oe=1.
  - The ones counter is set to 1 by the final 1.
  - After the 8th symbol → DATA.
- **DATA**
  - bit_ready = 1 when ones < MAX_ONES.
  - On transfer: drive NRZI(bit_in). The ones counter becomes ones+1 if bit_in=1, otherwise 0.
  - If ones == MAX_ONES: bit_ready=0, drive NRZI(0) (stuffed bit), and clear ones. The stuff has priority over the input.
  - Transfer with bit_last=1 → EOP_SE0, unless the transfer makes ones == MAX_ONES. In that case the stuffed 0 is emitted first, then EOP_SE0.
  - bit_valid=0 while bit_ready=1 → underrun. Pulse underrun and go to EOP_SE0 without emitting a data symbol.
- **EOP_SE0**
  - SE0_BITS cycles of dp=dm=0, oe=1, bit_ready=0.
- **EOP_J**
  - J_BITS cycles of J, oe=1.
  - Then → IDLE, with `lvl` reset to J and ones cleared.
- Inputs are ignored in SYNC, EOP_SE0 and EOP_J.
- Widths:
  - The ones counter is wide enough for MAX_ONES.
  - The phase counter is shared across SYNC and EOP and sized for max(8, SE0_BITS, J_BITS).
  - Counters never wrap; each state exits on an exact compare.

## Timing
- A packet start seen in IDLE at edge E produces SYNC symbols registered at edges E..E+7. DATA is entered at E+7, and bit_ready is first high in the cycle after E+7.
- Latency: a bit transferred at edge k appears on dp/dm after edge k (one register stage).
- A stuffed bit costs exactly one cycle with bit_ready=0.
- Packet line length is 8 + data bits + stuffed bits + SE0_BITS + J_BITS cycles with oe=1.
- At least one IDLE cycle (oe=0) separates packets. bit_valid held high across EOP starts the next SYNC one cycle after returning to IDLE.
- Reset asserted mid-packet forces all reset values immediately (asynchronous). No EOP is emitted.

## Test plan
- Full-speed ACK: bits 0,1,0,0,1,0,1,1 (last on 8th) → dp/dm sequence KJKJKJKK, JJKJJKKK, SE0, SE0, J, with oe high for exactly 19 cycles. No underrun.
- Stuffing mid-packet: eight 1s → stuff after the 5th data 1 (the SYNC 1 counts toward the run). Exactly one bit_ready=0 cycle. 9 data-phase symbols: K×5, J, J×3.
- Stuffing at the end: bits 0,1,1,1,1,1,1 (last on the final 1) → stuffed 0 emitted after the final 1, then SE0, SE0, J.
- Underrun: drop bit_valid after 3 data bits → underrun pulses exactly 1 cycle, SE0 follows immediately, then J, then IDLE with oe=0.
- LOW_SPEED=1, SE0_BITS=3, J_BITS=2: repeat the ACK case → every symbol has inverted polarity, 3 SE0 cycles, 2 J cycles, oe high for 21 cycles.
- Reset mid-packet: assert rst_b=0 in DATA → same cycle: oe=0, dp/dm=J, busy=0. After release with bit_valid=1, a fresh SYNC starts.
